bus_datapath_seq: RTL and testbench

- Parametrised, self-sequencing successor to the single-bus RA/RB/RZ datapath.
- Contents: a NREGS x WIDTH register file, a Y operand latch, an add/sub ALU and a Z result register, all sharing one internal bus.
- A control FSM steps each instruction through bus phases T1-T3 and reports completion with a done pulse.
- Feeds the future CPU control unit; the debug port exposes register contents to the testbench.

---
 rtl/bus_datapath_seq.sv | 96 +++++++++
 tb/tb_bus_datapath_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq: single-bus register-file datapath with a T1-T3 sequencer for LDI/ADD/SUB/MOV
module bus_datapath_seq #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     start,
   input  logic [1:0]               op,
   input  logic [$clog2(NREGS)-1:0] ra,
   input  logic [$clog2(NREGS)-1:0] rb,
   input  logic [$clog2(NREGS)-1:0] rc,
   input  logic [WIDTH-1:0]         imm,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH-1:0]         result,
   output logic                     cout,
   input  logic [$clog2(NREGS)-1:0] dbg_addr,
   output logic [WIDTH-1:0]         dbg_data
);
   localparam int AW = $clog2(NREGS);
   localparam logic [1:0] LDI = 2'b00, ADD = 2'b01, SUB = 2'b10, MOV = 2'b11;
   typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
   state_t state, state_nx;
   logic [1:0] op_l;
   logic [AW-1:0] ra_l, rb_l, rc_l;
   logic [WIDTH-1:0] imm_l, y, z, bus;
   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH:0] sum;
   logic carry, is_arith, is_sub;
   function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
      return (ZERO_R0 && a == '0) ? '0 : regs[a];
   endfunction
   assign is_arith = op_l == ADD || op_l == SUB;
   assign is_sub = op_l == SUB;
   assign dbg_data = rd(dbg_addr);
   // one bus driver per phase: source operand, second operand, then Z; idle bus is 0
   always_comb begin
      bus = state == T1 ? rd(rb_l) :
            state == T2 ? (op_l == LDI ? imm_l : op_l == MOV ? rd(rb_l) : rd(rc_l)) :
            state == T3 ? z : '0;
      sum = {1'b0, y} + {1'b0, is_sub ? ~bus : bus} + (WIDTH+1)'(is_sub);
   end
   // state register
   always_ff @(posedge clk) begin
      if (!clear) state <= IDLE;
      else state <= state_nx;
   end
   // next-state: start only matters in IDLE, phases advance unconditionally
   always_comb begin
      state_nx = state == IDLE ? (start ? T1 : IDLE) :
                 state == T1 ? T2 :
                 state == T2 ? T3 : IDLE;
   end
   // outputs decoded from state
   always_comb begin
      busy = state != IDLE;
   end
   // datapath registers: operand latch, Y, Z/carry, writeback and completion pulse
   always_ff @(posedge clk) begin
      if (!clear) begin
         op_l <= '0;
         ra_l <= '0;
         rb_l <= '0;
         rc_l <= '0;
         imm_l <= '0;
         y <= '0;
         z <= '0;
         carry <= 1'b0;
         result <= '0;
         cout <= 1'b0;
         done <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         done <= state == T3;
         if (state == IDLE && start) begin
            op_l <= op;
            ra_l <= ra;
            rb_l <= rb;
            rc_l <= rc;
            imm_l <= imm;
         end
         if (state == T1) y <= is_arith ? bus : '0;
         if (state == T2) begin
            z <= sum[WIDTH-1:0];
            carry <= sum[WIDTH];
         end
         if (state == T3) begin
            result <= bus;
            cout <= carry;
            if (!(ZERO_R0 && ra_l == '0)) regs[ra_l] <= bus;
         end
      end
   end
endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb_bus_datapath_seq: table vectors, handshake/reset sequences and random ops against a register-array model
module tb_bus_datapath_seq;
   logic clk = 1'b0, clear = 1'b0, start = 1'b0;
   logic [1:0] op = '0;
   logic [3:0] ra = '0, rb = '0, rc = '0, dbg_addr = '0;
   logic [31:0] imm = '0;
   logic busy, done, cout;
   logic [31:0] result, dbg_data;
   int checks = 0, errors = 0;
   logic [31:0] mreg [16];

   bus_datapath_seq #(.WIDTH(32), .NREGS(16), .ZERO_R0(1'b1)) dut (
      .clk(clk), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
      .imm(imm), .busy(busy), .done(done), .result(result), .cout(cout),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] o;
      logic [3:0] a, b, c;
      logic [31:0] im;
      logic [31:0] res;
      logic co;
      logic [31:0] dbg;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mrd(input logic [3:0] a);
      return a == 0 ? 32'h0 : mreg[a];
   endfunction

   // reference: result/carry from the instruction's meaning, not from bus phases
   task automatic model(input logic [1:0] o, input logic [3:0] b, c, input logic [31:0] im,
                        output logic [31:0] r, output logic co);
      logic [31:0] vb, vc;
      vb = mrd(b);
      vc = mrd(c);
      case (o)
         2'b00: begin r = im; co = 1'b0; end
         2'b01: begin r = vb + vc; co = (64'(vb) + 64'(vc)) >= 64'h1_0000_0000; end
         2'b10: begin r = vb - vc; co = vb >= vc; end
         default: begin r = vb; co = 1'b0; end
      endcase
   endtask

   task automatic do_op(input logic [1:0] o, input logic [3:0] a, b, c, input logic [31:0] im,
                        output logic [31:0] r, output logic co, output logic [31:0] d);
      logic [31:0] mr;
      logic mc;
      model(o, b, c, im, mr, mc);
      @(negedge clk);
      start = 1'b1; op = o; ra = a; rb = b; rc = c; imm = im;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("busy_t%0d", i + 1), 32'(busy), 32'd1);
         chk($sformatf("nodone_t%0d", i + 1), 32'(done), 32'd0);
         @(negedge clk);
      end
      chk("done", 32'(done), 32'd1);
      chk("idle_at_done", 32'(busy), 32'd0);
      chk("result", result, mr);
      chk("cout", 32'(cout), 32'(mc));
      dbg_addr = a;
      #1;
      chk("dbg_ra", dbg_data, a == 0 ? 32'h0 : mr);
      if (a != 0) mreg[a] = mr;
      r = result;
      co = cout;
      d = dbg_data;
   endtask

   task automatic dbg_all_zero(input string nm);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         chk($sformatf("%s_r%0d", nm, i), dbg_data, 32'h0);
      end
   endtask

   initial begin
      vec_t tbl [10];
      logic [31:0] r, d, junk, e;
      logic co;
      for (int i = 0; i < 16; i++) mreg[i] = 32'h0;
      tbl[0] = '{2'b00, 4'd3, 4'd0, 4'd0, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 32'h0000_00FF};
      tbl[1] = '{2'b00, 4'd3, 4'd0, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
      tbl[2] = '{2'b01, 4'd4, 4'd3, 4'd3, 32'h0,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFE};
      tbl[3] = '{2'b00, 4'd5, 4'd0, 4'd0, 32'd5,         32'd5,         1'b0, 32'd5};
      tbl[4] = '{2'b00, 4'd6, 4'd0, 4'd0, 32'd7,         32'd7,         1'b0, 32'd7};
      tbl[5] = '{2'b10, 4'd7, 4'd5, 4'd6, 32'h0,         32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE};
      tbl[6] = '{2'b10, 4'd8, 4'd6, 4'd5, 32'h0,         32'd2,         1'b1, 32'd2};
      tbl[7] = '{2'b00, 4'd0, 4'd0, 4'd0, 32'h1234,      32'h1234,      1'b0, 32'h0};
      tbl[8] = '{2'b11, 4'd9, 4'd4, 4'd0, 32'h5555,      32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE};
      tbl[9] = '{2'b01, 4'd3, 4'd3, 4'd3, 32'h0,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFE};

      // reset held for two cycles
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_cout", 32'(cout), 32'd0);
      dbg_all_zero("rst_dbg");
      clear = 1'b1;

      foreach (tbl[i]) begin
         do_op(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].im, r, co, d);
         chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
         chk($sformatf("tbl%0d_cout", i), 32'(co), 32'(tbl[i].co));
         chk($sformatf("tbl%0d_dbg", i), d, tbl[i].dbg);
      end

      // handshake: inputs churn while busy, then back-to-back start in the done cycle
      e = mreg[5] + mreg[6];
      @(negedge clk);
      start = 1'b1; op = 2'b01; ra = 4'd10; rb = 4'd5; rc = 4'd6;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         start = (i % 2 == 0);
         op = 2'b00; ra = 4'd11; rb = 4'd0; imm = $urandom;
         chk("hs_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      chk("hs_done", 32'(done), 32'd1);
      chk("hs_result", result, e);
      dbg_addr = 4'd11;
      #1;
      chk("hs_no_extra", dbg_data, 32'h0);
      mreg[10] = e;
      start = 1'b1; op = 2'b00; ra = 4'd11; imm = 32'h0000_0ABC;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("b2b_busy", 32'(busy), 32'd1);
         chk("b2b_nodone", 32'(done), 32'd0);
         @(negedge clk);
      end
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_result", result, 32'h0000_0ABC);
      #1;
      chk("b2b_dbg", dbg_data, 32'h0000_0ABC);
      mreg[11] = 32'h0000_0ABC;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("after_idle", 32'(busy), 32'd0);
         chk("after_nodone", 32'(done), 32'd0);
      end
      dbg_addr = 4'd10;
      #1;
      chk("hs_r10", dbg_data, e);

      // random ops checked against the model
      for (int n = 0; n < 40; n++)
         do_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), $urandom, r, co, d);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         chk($sformatf("rand_r%0d", i), dbg_data, mrd(4'(i)));
      end

      // reset during T2 aborts the op
      @(negedge clk);
      start = 1'b1; op = 2'b01; ra = 4'd9; rb = 4'd3; rc = 4'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done0", 32'(done), 32'd0);
      junk = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         junk = junk | 32'(done) | 32'(busy);
      end
      chk("abort_no_done", junk, 32'h0);
      chk("abort_result", result, 32'h0);
      chk("abort_cout", 32'(cout), 32'd0);
      dbg_all_zero("abort_dbg");
      for (int i = 0; i < 16; i++) mreg[i] = 32'h0;

      // datapath still works after the abort
      do_op(2'b00, 4'd2, 4'd0, 4'd0, 32'hDEAD_BEEF, r, co, d);
      chk("post_abort", r, 32'hDEAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
